// File: rtl/rs_chien_ctrl.sv
// Reed-Solomon Chien search controller: steps the candidate roots for an external
// evaluator, streams per-position error flags and reports the root count per codeword.

package gf_pkg;
  localparam int SYMB_WIDTH = 8;
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;
  typedef logic [SYMB_WIDTH-1:0] symb_t;
  localparam symb_t PRIM_LOW = PRIM_POLY[SYMB_WIDTH-1:0];

  function automatic symb_t gf_xtime(input symb_t a);
    return a[SYMB_WIDTH-1] ? ((a << 1) ^ PRIM_LOW) : (a << 1);
  endfunction

  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t acc;
    symb_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  function automatic symb_t gf_alpha_pow(input int n);
    symb_t r;
    r = symb_t'(1);
    for (int k = 0; k < n; k++) r = gf_xtime(r);
    return r;
  endfunction
endpackage

module rs_chien_ctrl #(
  parameter int SYMB_WIDTH      = gf_pkg::SYMB_WIDTH,
  parameter int T_LEN           = 8,
  parameter int ROOTS_PER_CYCLE = 4,
  parameter int N_LEN           = 255
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    loc_vld,
  output logic                                    loc_rdy,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]          loc_in,
  input  logic [$clog2(T_LEN+1)-1:0]              loc_deg,
  output logic [T_LEN:0][SYMB_WIDTH-1:0]          chien_locator,
  output logic [ROOTS_PER_CYCLE-1:0][SYMB_WIDTH-1:0] chien_roots,
  input  logic [ROOTS_PER_CYCLE-1:0]              chien_bit_pos,
  output logic                                    pos_vld,
  input  logic                                    pos_rdy,
  output logic [ROOTS_PER_CYCLE-1:0]              pos_bits,
  output logic                                    pos_last,
  output logic [$clog2(N_LEN+1)-1:0]              err_cnt,
  output logic                                    dec_fail
);

  localparam int R      = ROOTS_PER_CYCLE;
  localparam int STEPS  = (N_LEN + R - 1) / R;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int DEG_W  = $clog2(T_LEN + 1);
  localparam int CNT_W  = $clog2(N_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  typedef logic [R-1:0][SYMB_WIDTH-1:0] roots_t;

  function automatic roots_t init_roots_f();
    roots_t r;
    for (int i = 0; i < R; i++) r[i] = gf_pkg::gf_alpha_pow(i);
    return r;
  endfunction

  // Positions past the end of the codeword only exist on the last step.
  function automatic logic [R-1:0] last_mask_f();
    logic [R-1:0] m;
    for (int i = 0; i < R; i++) m[R-1-i] = (((STEPS - 1) * R + i) < N_LEN);
    return m;
  endfunction

  localparam roots_t            ROOT_INIT = init_roots_f();
  localparam logic [R-1:0]      LAST_MASK = last_mask_f();
  localparam gf_pkg::symb_t     ALPHA_R   = gf_pkg::gf_alpha_pow(R);

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN} state_t;

  state_t                        state_q, state_d;
  logic                          loc_rdy_q, loc_rdy_d;
  logic [T_LEN:0][SYMB_WIDTH-1:0] chien_locator_q, chien_locator_d;
  logic [DEG_W-1:0]              deg_q, deg_d;
  logic [STEP_W-1:0]             step_q, step_d;
  roots_t                        chien_roots_q, chien_roots_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          pos_vld_q, pos_vld_d;
  logic [R-1:0]                  pos_bits_q, pos_bits_d;
  logic                          pos_last_q, pos_last_d;
  logic [CNT_W-1:0]              err_cnt_q, err_cnt_d;
  logic                          dec_fail_q, dec_fail_d;

  logic [R-1:0]                  masked_bits;
  logic [CNT_W-1:0]              cnt_new;
  int                            pop;
  int                            sum_v;

  always_comb begin
    state_d         = state_q;
    chien_locator_d = chien_locator_q;
    deg_d           = deg_q;
    step_d          = step_q;
    chien_roots_d   = chien_roots_q;
    cnt_d           = cnt_q;
    pos_vld_d       = pos_vld_q;
    pos_bits_d      = pos_bits_q;
    pos_last_d      = pos_last_q;
    err_cnt_d       = err_cnt_q;
    dec_fail_d      = dec_fail_q;

    masked_bits = chien_bit_pos & ((step_q == LAST_STEP) ? LAST_MASK : {R{1'b1}});
    pop = 0;
    for (int i = 0; i < R; i++) pop = pop + int'(masked_bits[i]);
    sum_v   = int'(cnt_q) + pop;
    cnt_new = (sum_v > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(sum_v);

    unique case (state_q)
      IDLE: begin
        if (loc_vld) begin
          chien_locator_d = loc_in;
          deg_d           = loc_deg;
          step_d          = '0;
          chien_roots_d   = ROOT_INIT;
          cnt_d           = '0;
          state_d         = SEARCH;
        end
      end
      SEARCH: begin
        // Advance only when the output register is free or being drained this cycle.
        if (!pos_vld_q || pos_rdy) begin
          pos_bits_d = masked_bits;
          pos_vld_d  = 1'b1;
          cnt_d      = cnt_new;
          step_d     = step_q + STEP_W'(1);
          for (int i = 0; i < R; i++)
            chien_roots_d[i] = gf_pkg::gf_mult(chien_roots_q[i], ALPHA_R);
          if (step_q == LAST_STEP) begin
            pos_last_d = 1'b1;
            err_cnt_d  = cnt_new;
            dec_fail_d = (int'(cnt_new) != int'(deg_q));
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pos_rdy) begin
          pos_vld_d  = 1'b0;
          pos_last_d = 1'b0;
          dec_fail_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    loc_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      loc_rdy_q       <= 1'b1;
      chien_locator_q <= '0;
      deg_q           <= '0;
      step_q          <= '0;
      chien_roots_q   <= '0;
      cnt_q           <= '0;
      pos_vld_q       <= 1'b0;
      pos_bits_q      <= '0;
      pos_last_q      <= 1'b0;
      err_cnt_q       <= '0;
      dec_fail_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      loc_rdy_q       <= loc_rdy_d;
      chien_locator_q <= chien_locator_d;
      deg_q           <= deg_d;
      step_q          <= step_d;
      chien_roots_q   <= chien_roots_d;
      cnt_q           <= cnt_d;
      pos_vld_q       <= pos_vld_d;
      pos_bits_q      <= pos_bits_d;
      pos_last_q      <= pos_last_d;
      err_cnt_q       <= err_cnt_d;
      dec_fail_q      <= dec_fail_d;
    end
  end

  assign loc_rdy       = loc_rdy_q;
  assign chien_locator = chien_locator_q;
  assign chien_roots   = chien_roots_q;
  assign pos_vld       = pos_vld_q;
  assign pos_bits      = pos_bits_q;
  assign pos_last      = pos_last_q;
  assign err_cnt       = err_cnt_q;
  assign dec_fail      = dec_fail_q;

endmodule

// File: tb/tb_rs_chien_ctrl.sv
// Bench for rs_chien_ctrl: models the Chien evaluator and predicts every beat
// of each codeword into a scoreboard queue that is drained as beats are accepted.

module tb_rs_chien_ctrl;
  localparam int SW = 8;
  localparam int T = 8;
  localparam int R = 4;
  localparam int N = 255;
  localparam int STEPS = 64;

  typedef logic [T:0][SW-1:0] loc_t;
  typedef struct packed {
    logic [R-1:0] bits;
    logic         last;
    logic [7:0]   cnt;
    logic         fail;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 loc_vld = 1'b0;
  logic                 loc_rdy;
  loc_t                 loc_in = '0;
  logic [3:0]           loc_deg = '0;
  loc_t                 chien_locator;
  logic [R-1:0][SW-1:0] chien_roots;
  logic [R-1:0]         chien_bit_pos;
  logic                 pos_vld;
  logic                 pos_rdy = 1'b0;
  logic [R-1:0]         pos_bits;
  logic                 pos_last;
  logic [7:0]           err_cnt;
  logic                 dec_fail;

  int checks = 0;
  int errors = 0;
  beat_t expQ[$];
  logic [R-1:0] obsBits [STEPS];
  int obsCnt, obsFail, lastCyc, stalls, beatIdx;
  loc_t locA, locB;

  always #5 clk = ~clk;

  rs_chien_ctrl dut (
    .clk(clk), .rst(rst), .loc_vld(loc_vld), .loc_rdy(loc_rdy),
    .loc_in(loc_in), .loc_deg(loc_deg), .chien_locator(chien_locator),
    .chien_roots(chien_roots), .chien_bit_pos(chien_bit_pos),
    .pos_vld(pos_vld), .pos_rdy(pos_rdy), .pos_bits(pos_bits),
    .pos_last(pos_last), .err_cnt(err_cnt), .dec_fail(dec_fail)
  );

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gfMulTb(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (15'h11D << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] alphaPow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < n; k++) r = r[7] ? ((r << 1) ^ 8'h1D) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] evalPoly(input loc_t loc, input logic [7:0] x);
    logic [7:0] acc;
    acc = '0;
    for (int j = T; j >= 0; j--) acc = gfMulTb(acc, x) ^ loc[j];
    return acc;
  endfunction

  function automatic loc_t makePair(input int p1, input int p2);
    loc_t l;
    l = '0;
    l[0] = gfMulTb(alphaPow(p1), alphaPow(p2));
    l[1] = alphaPow(p1) ^ alphaPow(p2);
    l[2] = 8'h01;
    return l;
  endfunction

  function automatic logic rdyFor(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    return ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endfunction

  // Evaluator model: bit R-1-i flags chien_roots[i] as a root of the locator.
  always_comb begin
    chien_bit_pos = '0;
    for (int i = 0; i < R; i++)
      if (evalPoly(chien_locator, chien_roots[i]) == 8'h00) chien_bit_pos[R-1-i] = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpected(input loc_t loc, input int deg);
    beat_t b;
    int cnt;
    int p;
    cnt = 0;
    for (int k = 0; k < STEPS; k++) begin
      b.bits = '0;
      for (int i = 0; i < R; i++) begin
        p = k * R + i;
        if (p < N && evalPoly(loc, alphaPow(p)) == 8'h00) begin
          b.bits[R-1-i] = 1'b1;
          if (cnt < 255) cnt++;
        end
      end
      b.last = (k == STEPS - 1);
      b.cnt  = 8'(cnt);
      b.fail = (cnt != deg);
      expQ.push_back(b);
    end
  endtask

  // Leaves the bench on the falling edge right after the accepting rising edge.
  task automatic applyStimulus(input loc_t loc, input int deg, input bit keepVld);
    int w;
    w = 0;
    while (!loc_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("loc_rdy_wait", loc_rdy, 1);
    loc_vld = 1'b1;
    loc_in  = loc;
    loc_deg = 4'(deg);
    pushExpected(loc, deg);
    @(posedge clk);
    @(negedge clk);
    if (!keepVld) loc_vld = 1'b0;
  endtask

  task automatic runSearch(input int mode);
    bit done;
    bit prevStall;
    logic [R-1:0] prevBits;
    done = 0; prevStall = 0; prevBits = '0;
    stalls = 0; lastCyc = -1; beatIdx = 0; obsCnt = -1; obsFail = -1;
    checkOutput("first_beat_latency", pos_vld, 0);
    pos_rdy = rdyFor(mode, 0);
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      checkOutput("loc_rdy_busy", loc_rdy, 0);
      if (prevStall) checkOutput("hold_bits", pos_bits, prevBits);
      prevStall = 0;
      if (pos_vld) begin
        checkOutput("queue_nonempty", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          checkOutput("pos_bits", pos_bits, expQ[0].bits);
          checkOutput("pos_last", pos_last, expQ[0].last);
          if (expQ[0].last) begin
            checkOutput("err_cnt", err_cnt, expQ[0].cnt);
            checkOutput("dec_fail", dec_fail, expQ[0].fail);
            if (lastCyc < 0) lastCyc = cyc;
          end
        end
      end
      pos_rdy = rdyFor(mode, cyc);
      if (pos_vld && !pos_rdy) begin
        if (!pos_last) stalls++;
        prevStall = 1;
        prevBits  = pos_bits;
      end
      if (pos_vld && pos_rdy && expQ.size() != 0) begin
        if (beatIdx < STEPS) obsBits[beatIdx] = pos_bits;
        beatIdx++;
        if (expQ[0].last) begin
          done = 1;
          obsCnt = int'(err_cnt);
          obsFail = int'(dec_fail);
        end
        void'(expQ.pop_front());
      end
    end
    checkOutput("search_timeout", done, 1);
    checkOutput("beat_count", beatIdx, STEPS);
    @(negedge clk);
    checkOutput("drain_vld_clear", pos_vld, 0);
    checkOutput("drain_last_clear", pos_last, 0);
    checkOutput("idle_loc_rdy", loc_rdy, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pos_vld"}, pos_vld, 0);
    checkOutput({tag, "_pos_last"}, pos_last, 0);
    checkOutput({tag, "_pos_bits"}, pos_bits, 0);
    checkOutput({tag, "_err_cnt"}, err_cnt, 0);
    checkOutput({tag, "_dec_fail"}, dec_fail, 0);
    checkOutput({tag, "_locator"}, chien_locator, 0);
    checkOutput({tag, "_roots"}, chien_roots, 0);
  endtask

  initial begin
    locA = makePair(3, 100);
    locB = '0;
    locB[0] = 8'h01;
    locB[1] = 8'h01;

    // Power-on reset.
    @(negedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_loc_rdy", loc_rdy, 1);

    // Two errors, no backpressure.
    applyStimulus(locA, 2, 0);
    runSearch(0);
    checkOutput("two_err_last_cycle", lastCyc, STEPS);
    checkOutput("two_err_beat0", obsBits[0], 4'b0001);
    checkOutput("two_err_beat25", obsBits[25], 4'b1000);
    checkOutput("two_err_cnt", obsCnt, 2);
    checkOutput("two_err_fail", obsFail, 0);

    // Degree mismatch.
    applyStimulus(locA, 3, 0);
    runSearch(0);
    checkOutput("mismatch_cnt", obsCnt, 2);
    checkOutput("mismatch_fail", obsFail, 1);

    // Backpressure 1,0,0,1.
    applyStimulus(locA, 2, 0);
    runSearch(1);
    checkOutput("bp_stalls_seen", stalls > 0, 1);
    checkOutput("bp_last_cycle", lastCyc, STEPS + stalls);
    checkOutput("bp_cnt", obsCnt, 2);
    checkOutput("bp_beat25", obsBits[25], 4'b1000);

    // Root at alpha^0 = alpha^255: position 0 counts, padded position 255 does not.
    pos_rdy = 1'b1;
    applyStimulus(locB, 1, 0);
    runSearch(0);
    checkOutput("pad_beat0", obsBits[0], 4'b1000);
    checkOutput("pad_beat63", obsBits[63], 4'b0000);
    checkOutput("pad_cnt", obsCnt, 1);
    checkOutput("pad_fail", obsFail, 0);

    // Zero degree still searches every step.
    applyStimulus(locA, 0, 0);
    runSearch(0);
    checkOutput("deg0_cnt", obsCnt, 2);
    checkOutput("deg0_fail", obsFail, 1);

    // Reset at step 20.
    applyStimulus(locA, 2, 0);
    pos_rdy = 1'b1;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    checkOutput("pre_reset_vld", pos_vld, 1);
    rst = 1'b1;
    #1;
    checkResetState("midreset");
    expQ.delete();
    @(negedge clk);
    checkResetState("midreset_hold");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_loc_rdy", loc_rdy, 1);
    checkOutput("midreset_no_vld", pos_vld, 0);
    applyStimulus(locA, 2, 0);
    runSearch(0);
    checkOutput("after_reset_cnt", obsCnt, 2);

    // Back-to-back with loc_vld held high; the second locator waits for IDLE.
    applyStimulus(locA, 2, 1);
    loc_in  = locB;
    loc_deg = 4'd1;
    pushExpected(locB, 1);
    runSearch(0);
    checkOutput("b2b_first_cnt", obsCnt, 2);
    checkOutput("b2b_first_fail", obsFail, 0);
    @(posedge clk);
    @(negedge clk);
    loc_vld = 1'b0;
    checkOutput("b2b_second_taken", loc_rdy, 0);
    runSearch(0);
    checkOutput("b2b_second_cnt", obsCnt, 1);
    checkOutput("b2b_queue_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
